// File: rtl/stream_decryptor_if.sv
// Stream and key-programming bundle for stream_decryptor: ciphertext in, plaintext out,
// key write port and status flags.
interface stream_decryptor_if #(
    parameter int unsigned SEC_LEN = 3
);
    localparam int unsigned KW = (SEC_LEN > 1) ? $clog2(SEC_LEN) : 1;

    logic          key_we;
    logic [KW-1:0] key_addr;
    logic [7:0]    key_data;
    logic          s_valid;
    logic          s_ready;
    logic [7:0]    s_data;
    logic          s_last;
    logic          m_valid;
    logic          m_ready;
    logic [7:0]    m_data;
    logic          m_last;
    logic          m_err;
    logic          cfg_err;
    logic          busy;

    modport slave (
        input  key_we, key_addr, key_data, s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, m_last, m_err, cfg_err, busy
    );

    modport master (
        output key_we, key_addr, key_data, s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_last, m_err, cfg_err, busy
    );
endinterface

// File: rtl/stream_decryptor.sv
// Two-stage byte-serial decryptor for the 62-symbol alphanumeric shift cipher.
// Optional macro PASSTHRU_INVALID_EN: forward invalid ciphertext bytes unchanged instead of 8'hFF.
module stream_decryptor #(
    parameter int unsigned MSG_LEN = 6,
    parameter int unsigned SEC_LEN = 3
) (
    input logic               clk,
    input logic               rst,
    stream_decryptor_if.slave bus
);
    localparam int unsigned KW = (SEC_LEN > 1) ? $clog2(SEC_LEN) : 1;
    localparam int unsigned CW = $clog2(MSG_LEN + 1);

    function automatic logic [7:0] char_pos(input logic [7:0] c);
        if (c >= 8'h41 && c <= 8'h5A) return c - 8'h41;
        else if (c >= 8'h61 && c <= 8'h7A) return c - 8'h61 + 8'd26;
        else if (c >= 8'h30 && c <= 8'h39) return c - 8'h30 + 8'd52;
        else return 8'hFF;
    endfunction

    function automatic logic [7:0] pos_char(input logic [5:0] p);
        if (p < 6'd26) return 8'h41 + {2'b00, p};
        else if (p < 6'd52) return 8'h61 + {2'b00, p} - 8'd26;
        else return 8'h30 + {2'b00, p} - 8'd52;
    endfunction

    logic [7:0]    key_q [SEC_LEN];
    logic [KW-1:0] kidx_q;
    logic [CW-1:0] cnt_q;
    logic          s1_v_q, s1_inv_q, s1_last_q;
    logic [5:0]    s1_cpos_q, s1_kpos_q;
`ifdef PASSTHRU_INVALID_EN
    logic [7:0]    s1_raw_q;
`endif
    logic          s2_v_q, s2_last_q, s2_err_q;
    logic [7:0]    s2_data_q;
    logic          cfg_err_q;

    logic          s1_adv, s2_adv, acc, busy, in_inv, msg_end, key_wr_ok;
    logic [7:0]    in_pos, key_pos_raw, inv_data;
    logic [5:0]    key_pos, modp;
    logic [6:0]    diff;
    logic [KW-1:0] kidx_nxt;

    always_comb begin
        s2_adv      = !s2_v_q || bus.m_ready;
        s1_adv      = !s1_v_q || s2_adv;
        acc         = bus.s_valid && !rst && s1_adv;
        busy        = s1_v_q || s2_v_q || (kidx_q != '0);
        in_pos      = char_pos(bus.s_data);
        in_inv      = (in_pos == 8'hFF);
        key_pos_raw = char_pos(key_q[kidx_q]);
        // An out-of-alphabet key byte acts as shift 0.
        key_pos     = (key_pos_raw == 8'hFF) ? 6'd0 : key_pos_raw[5:0];
        msg_end     = bus.s_last || (cnt_q == CW'(MSG_LEN - 1));
        kidx_nxt    = (kidx_q == KW'(SEC_LEN - 1)) ? '0 : kidx_q + KW'(1);
        key_wr_ok   = !busy && !acc && (32'(bus.key_addr) < SEC_LEN);
        diff        = {1'b0, s1_cpos_q} - {1'b0, s1_kpos_q};
        // Negative difference wraps by +62; mod-64 low bits give the same 0..61 result.
        modp        = diff[6] ? diff[5:0] + 6'd62 : diff[5:0];
`ifdef PASSTHRU_INVALID_EN
        inv_data    = s1_raw_q;
`else
        inv_data    = 8'hFF;
`endif
    end

    assign bus.s_ready = !rst && s1_adv;
    assign bus.m_valid = s2_v_q;
    assign bus.m_data  = s2_data_q;
    assign bus.m_last  = s2_last_q;
    assign bus.m_err   = s2_err_q;
    assign bus.cfg_err = cfg_err_q;
    assign bus.busy    = busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(SEC_LEN); i++) key_q[i] <= 8'h41;
            kidx_q    <= '0;
            cnt_q     <= '0;
            s1_v_q    <= 1'b0;
            s1_inv_q  <= 1'b0;
            s1_last_q <= 1'b0;
            s1_cpos_q <= '0;
            s1_kpos_q <= '0;
`ifdef PASSTHRU_INVALID_EN
            s1_raw_q  <= '0;
`endif
            s2_v_q    <= 1'b0;
            s2_last_q <= 1'b0;
            s2_err_q  <= 1'b0;
            s2_data_q <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_v_q <= acc;
                if (acc) begin
                    s1_cpos_q <= in_pos[5:0];
                    s1_inv_q  <= in_inv;
                    s1_kpos_q <= key_pos;
                    s1_last_q <= msg_end;
`ifdef PASSTHRU_INVALID_EN
                    s1_raw_q  <= bus.s_data;
`endif
                end
            end
            if (s2_adv) begin
                s2_v_q <= s1_v_q;
                if (s1_v_q) begin
                    s2_data_q <= s1_inv_q ? inv_data : pos_char(modp);
                    s2_last_q <= s1_last_q;
                    s2_err_q  <= s1_inv_q;
                end
            end
            if (acc) begin
                if (msg_end) begin
                    cnt_q  <= '0;
                    kidx_q <= '0;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                    if (!in_inv) kidx_q <= kidx_nxt;
                end
            end
            if (bus.key_we) begin
                if (key_wr_ok) begin
                    key_q[bus.key_addr] <= bus.key_data;
                    if (char_pos(bus.key_data) == 8'hFF) cfg_err_q <= 1'b1;
                end else begin
                    cfg_err_q <= 1'b1;
                end
            end
        end
    end
endmodule
